// File: rtl/rice_core_csr_access_ctrl.sv
// CSR access sequencer: turns one CSRRW/CSRRS/CSRRC request into a read and/or
// write on the CSR bus, with flush and illegal-access handling.
module rice_core_csr_access_ctrl #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_enable,
  input  logic            i_flush,
  input  logic            i_req_valid,
  output logic            o_req_ready,
  input  logic [1:0]      i_req_op,
  input  logic [11:0]     i_req_address,
  input  logic [XLEN-1:0] i_req_data,
  input  logic            i_req_rd_zero,
  input  logic            i_req_src_zero,
  output logic            o_rsp_valid,
  input  logic            i_rsp_ready,
  output logic [XLEN-1:0] o_rsp_data,
  output logic            o_rsp_error,
  output logic            o_csr_request_valid,
  input  logic            i_csr_request_ready,
  output logic [11:0]     o_csr_address,
  output logic            o_csr_write,
  output logic [XLEN-1:0] o_csr_write_data,
  input  logic            i_csr_response_valid,
  input  logic [XLEN-1:0] i_csr_read_data,
  input  logic            i_csr_error,
  output logic            o_busy,
  output logic [2:0]      o_dbg_state
);

  // Handshakes: a transfer happens on a rising clock edge where valid and ready
  // are both high; valid never depends on ready, and the request payload holds
  // stable while valid is high and ready is low.

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_WR_WAIT = 3'd4;
  localparam logic [2:0] S_RSP     = 3'd5;

  localparam logic [1:0] OP_RW = 2'b01;
  localparam logic [1:0] OP_RS = 2'b10;
  localparam logic [1:0] OP_RC = 2'b11;

  logic [2:0]      state_q, state_d;
  logic [1:0]      op_q, op_d;
  logic [11:0]     addr_q, addr_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            need_write_q, need_write_d;
  logic            discard_q, discard_d;
  logic [XLEN-1:0] rsp_data_q, rsp_data_d;
  logic            rsp_err_q, rsp_err_d;
  logic [XLEN-1:0] wdata_q, wdata_d;

  logic            accept;
  logic            req_need_read;
  logic            req_need_write;
  logic            req_illegal;
  logic            flush_seen;
  logic [XLEN-1:0] merge_data;

  assign o_req_ready    = (state_q == S_IDLE) & i_enable & ~i_flush & ~i_rst;
  assign accept         = o_req_ready & i_req_valid;
  assign req_need_read  = !((i_req_op == OP_RW) && i_req_rd_zero);
  assign req_need_write = (i_req_op == OP_RW) || !i_req_src_zero;
  // A write to address[11:10] == 2'b11 targets a read-only CSR.
  assign req_illegal    = (i_req_op == 2'b00) ||
                          (req_need_write && (i_req_address[11:10] == 2'b11));
  // A flush arriving on the same cycle as the bus response still discards.
  assign flush_seen     = discard_q | i_flush;

  always_comb begin
    case (op_q)
      OP_RS:   merge_data = i_csr_read_data | data_q;
      OP_RC:   merge_data = i_csr_read_data & ~data_q;
      default: merge_data = data_q;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    op_d         = op_q;
    addr_d       = addr_q;
    data_d       = data_q;
    need_write_d = need_write_q;
    discard_d    = discard_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    wdata_d      = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d         = i_req_op;
          addr_d       = i_req_address;
          data_d       = i_req_data;
          need_write_d = req_need_write;
          discard_d    = 1'b0;
          rsp_data_d   = '0;
          rsp_err_d    = 1'b0;
          if (req_illegal) begin
            rsp_err_d = 1'b1;
            state_d   = S_RSP;
          end else if (req_need_read) begin
            state_d = S_RD_REQ;
          end else begin
            wdata_d = i_req_data;
            state_d = S_WR_REQ;
          end
        end
      end
      S_RD_REQ: begin
        if (i_flush) discard_d = 1'b1;
        if (i_csr_request_ready) state_d = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (i_flush) discard_d = 1'b1;
        if (i_csr_response_valid) begin
          rsp_data_d = i_csr_read_data;
          if (i_csr_error) begin
            rsp_err_d = 1'b1;
            state_d   = flush_seen ? S_IDLE : S_RSP;
          end else if (need_write_q && !flush_seen) begin
            wdata_d = merge_data;
            state_d = S_WR_REQ;
          end else begin
            state_d = flush_seen ? S_IDLE : S_RSP;
          end
        end
      end
      S_WR_REQ: begin
        if (i_flush) discard_d = 1'b1;
        if (i_csr_request_ready) state_d = S_WR_WAIT;
      end
      S_WR_WAIT: begin
        if (i_flush) discard_d = 1'b1;
        if (i_csr_response_valid) begin
          rsp_err_d = i_csr_error;
          state_d   = flush_seen ? S_IDLE : S_RSP;
        end
      end
      S_RSP: begin
        if (i_flush || i_rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      op_q         <= 2'b00;
      addr_q       <= '0;
      data_q       <= '0;
      need_write_q <= 1'b0;
      discard_q    <= 1'b0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      need_write_q <= need_write_d;
      discard_q    <= discard_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      wdata_q      <= wdata_d;
    end
  end

  // A response being flushed is withdrawn in the same cycle so it cannot handshake.
  assign o_rsp_valid         = (state_q == S_RSP) & ~i_flush;
  assign o_rsp_data          = rsp_data_q;
  assign o_rsp_error         = rsp_err_q;
  assign o_csr_request_valid = (state_q == S_RD_REQ) | (state_q == S_WR_REQ);
  assign o_csr_address       = addr_q;
  assign o_csr_write         = (state_q == S_WR_REQ);
  assign o_csr_write_data    = wdata_q;
  assign o_busy              = (state_q != S_IDLE);
  assign o_dbg_state         = state_q;

endmodule

// File: tb/tb_rice_core_csr_access_ctrl.sv
// Bench for rice_core_csr_access_ctrl: CSR bus responder model, response
// scoreboard, and directed plus randomised scenarios.
module tb_rice_core_csr_access_ctrl;
  localparam int XLEN = 32;

  logic            i_clk = 1'b0;
  logic            i_rst, i_enable, i_flush;
  logic            i_req_valid, o_req_ready;
  logic [1:0]      i_req_op;
  logic [11:0]     i_req_address;
  logic [XLEN-1:0] i_req_data;
  logic            i_req_rd_zero, i_req_src_zero;
  logic            o_rsp_valid, i_rsp_ready;
  logic [XLEN-1:0] o_rsp_data;
  logic            o_rsp_error;
  logic            o_csr_request_valid, i_csr_request_ready;
  logic [11:0]     o_csr_address;
  logic            o_csr_write;
  logic [XLEN-1:0] o_csr_write_data;
  logic            i_csr_response_valid;
  logic [XLEN-1:0] i_csr_read_data;
  logic            i_csr_error;
  logic            o_busy;
  logic [2:0]      o_dbg_state;

  rice_core_csr_access_ctrl #(.XLEN(XLEN)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_enable(i_enable), .i_flush(i_flush),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready), .i_req_op(i_req_op),
    .i_req_address(i_req_address), .i_req_data(i_req_data),
    .i_req_rd_zero(i_req_rd_zero), .i_req_src_zero(i_req_src_zero),
    .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data),
    .o_rsp_error(o_rsp_error), .o_csr_request_valid(o_csr_request_valid),
    .i_csr_request_ready(i_csr_request_ready), .o_csr_address(o_csr_address),
    .o_csr_write(o_csr_write), .o_csr_write_data(o_csr_write_data),
    .i_csr_response_valid(i_csr_response_valid), .i_csr_read_data(i_csr_read_data),
    .i_csr_error(i_csr_error), .o_busy(o_busy), .o_dbg_state(o_dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 i_clk = ~i_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [XLEN:0]   exp_q[$];      // {error, data}
  logic [44:0]     exp_bus_q[$];  // {write, address, write data}
  logic [31:0]     csr_mem [logic [11:0]];
  int              stall_cfg = 0;
  int              lat_cfg   = 1;
  bit              err_en    = 1'b0;
  logic [11:0]     err_addr  = 12'h7FF;
  bit              rnd_ready = 1'b0;

  // ---------------- CSR bus responder + bus scoreboard ----------------
  initial begin : bus_model
    int          stall_left;
    int          resp_cnt;
    bit          in_req;
    bit          pend_wr;
    logic [11:0] pend_addr;
    logic [31:0] pend_data;
    logic [44:0] e;
    stall_left = 0; resp_cnt = 0; in_req = 0; pend_wr = 0;
    pend_addr = '0; pend_data = '0;
    i_csr_request_ready = 0; i_csr_response_valid = 0;
    i_csr_read_data = '0; i_csr_error = 0;
    forever begin
      @(posedge i_clk); #2;
      i_csr_response_valid = 0;
      i_csr_error = 0;
      if (i_rst) begin
        resp_cnt = 0; in_req = 0; i_csr_request_ready = 0;
      end else begin
        if (resp_cnt > 0) begin
          resp_cnt--;
          if (resp_cnt == 0) begin
            i_csr_response_valid = 1;
            i_csr_read_data = csr_mem.exists(pend_addr) ? csr_mem[pend_addr] : 32'h0;
            i_csr_error = err_en && (pend_addr == err_addr);
            if (pend_wr && !i_csr_error) csr_mem[pend_addr] = pend_data;
          end
        end
        if (o_csr_request_valid) begin
          if (!in_req) begin in_req = 1; stall_left = stall_cfg; end
          if (stall_left > 0) begin
            stall_left--;
            i_csr_request_ready = 0;
          end else begin
            i_csr_request_ready = 1;
            in_req = 0;
            pend_wr = o_csr_write; pend_addr = o_csr_address; pend_data = o_csr_write_data;
            resp_cnt = lat_cfg;
            vec_cnt++;
            if (exp_bus_q.size() == 0) begin
              err_cnt++;
              $display("FAIL bus_access: unexpected write=%0b addr=%h data=%h", o_csr_write, o_csr_address, o_csr_write_data);
            end else begin
              e = exp_bus_q.pop_front();
              if (e[44] !== o_csr_write || e[43:32] !== o_csr_address || (e[44] && e[31:0] !== o_csr_write_data)) begin
                err_cnt++;
                $display("FAIL bus_access: got write=%0b addr=%h data=%h, expected write=%0b addr=%h data=%h",
                         o_csr_write, o_csr_address, o_csr_write_data, e[44], e[43:32], e[31:0]);
              end
            end
          end
        end else begin
          i_csr_request_ready = 0;
        end
      end
    end
  end

  // ---------------- response scoreboard ----------------
  initial begin : rsp_monitor
    logic [XLEN:0] e;
    forever begin
      @(posedge i_clk); #3;
      if (!i_rst && o_rsp_valid && i_rsp_ready) begin
        vec_cnt++;
        if (exp_q.size() == 0) begin
          err_cnt++;
          $display("FAIL rsp: unexpected response err=%0b data=%h", o_rsp_error, o_rsp_data);
        end else begin
          e = exp_q.pop_front();
          if ({o_rsp_error, o_rsp_data} !== e) begin
            err_cnt++;
            $display("FAIL rsp: got err=%0b data=%h, expected err=%0b data=%h", o_rsp_error, o_rsp_data, e[XLEN], e[XLEN-1:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic issue(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] data,
                       input bit rdz, input bit srcz);
    int t;
    @(posedge i_clk); #1;
    i_req_op = op; i_req_address = addr; i_req_data = data;
    i_req_rd_zero = rdz; i_req_src_zero = srcz; i_req_valid = 1;
    t = 0;
    while (!o_req_ready && t < 50) begin @(posedge i_clk); #1; t++; end
    vec_cnt++;
    if (o_req_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL issue_accept: o_req_ready=%b after %0d cycles, expected 1", o_req_ready, t);
    end
    @(posedge i_clk); #1;
    i_req_valid = 0;
  endtask

  task automatic wait_idle(input int max);
    int t;
    t = 0;
    do begin
      @(posedge i_clk); #1;
      if (rnd_ready) i_rsp_ready = ($urandom_range(0, 2) != 0);
      t++;
    end while (o_busy && t < max);
    vec_cnt++;
    if (o_busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL wait_idle: o_busy=%b after %0d cycles, expected 0", o_busy, t);
    end
    i_rsp_ready = 1;
    repeat (2) @(posedge i_clk);
    #1;
  endtask

  task automatic check_drained(input string name);
    vec_cnt++;
    if (exp_q.size() != 0 || exp_bus_q.size() != 0) begin
      err_cnt++;
      $display("FAIL %s_drained: %0d responses and %0d bus accesses outstanding, expected 0 and 0",
               name, exp_q.size(), exp_bus_q.size());
      exp_q.delete(); exp_bus_q.delete();
    end
  endtask

  task automatic push_expect(input logic [1:0] op, input logic [11:0] addr, input logic [31:0] data,
                             input bit rdz, input bit srcz);
    bit          nr, nw;
    logic [31:0] old, wd;
    nr  = !(op == 2'b01 && rdz);
    nw  = (op == 2'b01) || !srcz;
    old = csr_mem.exists(addr) ? csr_mem[addr] : 32'h0;
    if (op == 2'b00 || (nw && addr[11:10] == 2'b11)) begin
      exp_q.push_back({1'b1, 32'h0});
    end else begin
      if (nr) exp_bus_q.push_back({1'b0, addr, 32'h0});
      if (nw) begin
        case (op)
          2'b01:   wd = data;
          2'b10:   wd = old | data;
          default: wd = old & ~data;
        endcase
        exp_bus_q.push_back({1'b1, addr, wd});
      end
      exp_q.push_back({1'b0, nr ? old : 32'h0});
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    i_rst = 1; i_enable = 1; i_flush = 0; i_req_valid = 0; i_req_op = 0;
    i_req_address = 0; i_req_data = 0; i_req_rd_zero = 0; i_req_src_zero = 0; i_rsp_ready = 1;
    repeat (3) @(posedge i_clk);
    #1;
    vec_cnt++;
    if ({o_req_ready, o_rsp_valid, o_rsp_error, o_csr_request_valid, o_csr_write, o_busy} !== 6'b0) begin
      err_cnt++;
      $display("FAIL reset_flags: got %b, expected 000000",
               {o_req_ready, o_rsp_valid, o_rsp_error, o_csr_request_valid, o_csr_write, o_busy});
    end
    vec_cnt++;
    if (o_rsp_data !== 32'h0 || o_csr_write_data !== 32'h0 || o_csr_address !== 12'h0) begin
      err_cnt++;
      $display("FAIL reset_data: rsp_data=%h wdata=%h addr=%h, expected all 0", o_rsp_data, o_csr_write_data, o_csr_address);
    end
    i_rst = 0;
    #1;
    vec_cnt++;
    if (o_req_ready !== 1'b1 || o_dbg_state !== 3'd0) begin
      err_cnt++;
      $display("FAIL reset_release: req_ready=%b state=%0d, expected 1 and 0", o_req_ready, o_dbg_state);
    end
  endtask

  task automatic test_csrrs();
    csr_mem[12'h300] = 32'h0000_0008;
    exp_bus_q.push_back({1'b0, 12'h300, 32'h0});
    exp_bus_q.push_back({1'b1, 12'h300, 32'h0000_0088});
    exp_q.push_back({1'b0, 32'h0000_0008});
    issue(2'b10, 12'h300, 32'h0000_0080, 0, 0);
    wait_idle(100);
    vec_cnt++;
    if (csr_mem[12'h300] !== 32'h0000_0088) begin
      err_cnt++;
      $display("FAIL csrrs_mem: got %h, expected 00000088", csr_mem[12'h300]);
    end
    check_drained("csrrs");
  endtask

  task automatic test_csrrw_rdzero();
    csr_mem[12'h340] = 32'hAAAA_5555;
    exp_bus_q.push_back({1'b1, 12'h340, 32'h1234_5678});
    exp_q.push_back({1'b0, 32'h0});
    issue(2'b01, 12'h340, 32'h1234_5678, 1, 0);
    wait_idle(100);
    vec_cnt++;
    if (csr_mem[12'h340] !== 32'h1234_5678) begin
      err_cnt++;
      $display("FAIL csrrw_mem: got %h, expected 12345678", csr_mem[12'h340]);
    end
    check_drained("csrrw");
  endtask

  task automatic test_readonly();
    csr_mem[12'hC00] = 32'h0000_0055;
    exp_bus_q.push_back({1'b0, 12'hC00, 32'h0});
    exp_q.push_back({1'b0, 32'h0000_0055});
    issue(2'b10, 12'hC00, 32'h0, 0, 1);
    wait_idle(100);
    exp_q.push_back({1'b1, 32'h0});
    issue(2'b11, 12'hC00, 32'h0000_0001, 0, 0);
    wait_idle(100);
    exp_q.push_back({1'b1, 32'h0});
    issue(2'b00, 12'h300, 32'h0000_0005, 0, 0);
    wait_idle(100);
    check_drained("readonly");
  endtask

  task automatic test_rd_error();
    err_en = 1;
    csr_mem[12'h7FF] = 32'h0000_0BAD;
    exp_bus_q.push_back({1'b0, 12'h7FF, 32'h0});
    exp_q.push_back({1'b1, 32'h0000_0BAD});
    issue(2'b10, 12'h7FF, 32'h0000_0001, 0, 0);
    wait_idle(100);
    exp_bus_q.push_back({1'b1, 12'h7FF, 32'h0000_0099});
    exp_q.push_back({1'b1, 32'h0});
    issue(2'b01, 12'h7FF, 32'h0000_0099, 1, 0);
    wait_idle(100);
    err_en = 0;
    vec_cnt++;
    if (csr_mem[12'h7FF] !== 32'h0000_0BAD) begin
      err_cnt++;
      $display("FAIL rd_error_mem: got %h, expected 00000bad", csr_mem[12'h7FF]);
    end
    check_drained("rd_error");
  endtask

  task automatic test_flush_rd_wait();
    int t;
    stall_cfg = 5; lat_cfg = 3;
    csr_mem[12'h305] = 32'h0000_000F;
    exp_bus_q.push_back({1'b0, 12'h305, 32'h0});
    issue(2'b10, 12'h305, 32'h0000_00F0, 0, 0);
    t = 0;
    while (o_dbg_state === 3'd1 && t < 50) begin
      vec_cnt++;
      if (o_csr_request_valid !== 1'b1 || o_csr_address !== 12'h305 || o_csr_write !== 1'b0) begin
        err_cnt++;
        $display("FAIL flush_req_stable: valid=%b addr=%h write=%b, expected 1 305 0",
                 o_csr_request_valid, o_csr_address, o_csr_write);
      end
      t++;
      @(posedge i_clk); #1;
    end
    vec_cnt++;
    if (t !== 6) begin
      err_cnt++;
      $display("FAIL flush_req_cycles: got %0d, expected 6", t);
    end
    vec_cnt++;
    if (o_dbg_state !== 3'd2) begin
      err_cnt++;
      $display("FAIL flush_rd_wait_state: got %0d, expected 2", o_dbg_state);
    end
    i_flush = 1;
    @(posedge i_clk); #1;
    i_flush = 0;
    t = 0;
    do begin @(posedge i_clk); #3; t++; end while (!i_csr_response_valid && t < 20);
    vec_cnt++;
    if (i_csr_response_valid !== 1'b1) begin
      err_cnt++;
      $display("FAIL flush_read_done: response valid=%b, expected 1", i_csr_response_valid);
    end
    @(posedge i_clk); #1;
    vec_cnt++;
    if (o_busy !== 1'b0 || o_rsp_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL flush_idle: busy=%b rsp_valid=%b, expected 0 0", o_busy, o_rsp_valid);
    end
    stall_cfg = 0; lat_cfg = 1;
    repeat (4) @(posedge i_clk);
    #1;
    check_drained("flush_rd");
  endtask

  task automatic test_rsp_stall();
    int t;
    csr_mem[12'h301] = 32'h0000_0011;
    exp_bus_q.push_back({1'b0, 12'h301, 32'h0});
    exp_bus_q.push_back({1'b1, 12'h301, 32'h0000_0013});
    exp_q.push_back({1'b0, 32'h0000_0011});
    i_rsp_ready = 0;
    issue(2'b10, 12'h301, 32'h0000_0002, 0, 0);
    t = 0;
    while (!o_rsp_valid && t < 50) begin @(posedge i_clk); #1; t++; end
    for (int i = 0; i < 4; i++) begin
      vec_cnt++;
      if (o_rsp_valid !== 1'b1 || o_rsp_data !== 32'h0000_0011 || o_rsp_error !== 1'b0) begin
        err_cnt++;
        $display("FAIL rsp_hold: valid=%b data=%h err=%b, expected 1 00000011 0", o_rsp_valid, o_rsp_data, o_rsp_error);
      end
      if (i < 3) begin @(posedge i_clk); #1; end
    end
    i_rsp_ready = 1;
    wait_idle(20);
    check_drained("rsp_stall");
  endtask

  task automatic test_flush_rsp();
    int t;
    exp_bus_q.push_back({1'b1, 12'h342, 32'h0000_0005});
    i_rsp_ready = 0;
    issue(2'b01, 12'h342, 32'h0000_0005, 1, 0);
    t = 0;
    while (!o_rsp_valid && t < 50) begin @(posedge i_clk); #1; t++; end
    i_flush = 1;
    @(posedge i_clk); #1;
    i_flush = 0;
    vec_cnt++;
    if (o_busy !== 1'b0 || o_rsp_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL flush_rsp: busy=%b rsp_valid=%b, expected 0 0", o_busy, o_rsp_valid);
    end
    i_rsp_ready = 1;
    repeat (3) @(posedge i_clk);
    #1;
    check_drained("flush_rsp");
  endtask

  task automatic test_reset_mid();
    int t;
    lat_cfg = 4;
    exp_bus_q.push_back({1'b1, 12'h343, 32'h0000_0077});
    issue(2'b01, 12'h343, 32'h0000_0077, 1, 0);
    t = 0;
    while (o_dbg_state !== 3'd4 && t < 20) begin @(posedge i_clk); #1; t++; end
    vec_cnt++;
    if (o_dbg_state !== 3'd4) begin
      err_cnt++;
      $display("FAIL reset_mid_reach: state=%0d, expected 4", o_dbg_state);
    end
    i_rst = 1;
    #1;
    vec_cnt++;
    if ({o_req_ready, o_rsp_valid, o_rsp_error, o_csr_request_valid, o_csr_write, o_busy} !== 6'b0 ||
        o_rsp_data !== 32'h0 || o_csr_address !== 12'h0 || o_csr_write_data !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_mid_outputs: flags=%b rsp_data=%h addr=%h wdata=%h, expected all 0",
               {o_req_ready, o_rsp_valid, o_rsp_error, o_csr_request_valid, o_csr_write, o_busy},
               o_rsp_data, o_csr_address, o_csr_write_data);
    end
    repeat (2) @(posedge i_clk);
    #1;
    i_rst = 0;
    lat_cfg = 1;
    repeat (3) @(posedge i_clk);
    #1;
    vec_cnt++;
    if (o_busy !== 1'b0 || o_rsp_valid !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_mid_after: busy=%b rsp_valid=%b, expected 0 0", o_busy, o_rsp_valid);
    end
    check_drained("reset_mid");
  endtask

  task automatic test_enable();
    i_enable = 0;
    @(posedge i_clk); #1;
    i_req_op = 2'b01; i_req_address = 12'h344; i_req_data = 32'h1; i_req_valid = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vec_cnt++;
      if (o_req_ready !== 1'b0 || o_busy !== 1'b0) begin
        err_cnt++;
        $display("FAIL enable_block: req_ready=%b busy=%b, expected 0 0", o_req_ready, o_busy);
      end
      @(posedge i_clk); #1;
    end
    i_req_valid = 0;
    i_enable = 1;
    push_expect(2'b10, 12'h310, 32'h0000_0003, 0, 0);
    issue(2'b10, 12'h310, 32'h0000_0003, 0, 0);
    i_enable = 0;
    wait_idle(100);
    i_enable = 1;
    check_drained("enable");
  endtask

  task automatic test_back_to_back();
    logic [1:0]  op;
    logic [11:0] addr;
    logic [31:0] data;
    bit          rdz, srcz;
    rnd_ready = 1;
    for (int n = 0; n < 24; n++) begin
      op   = 2'($urandom_range(0, 3));
      addr = {2'($urandom_range(0, 3)), 8'h00, 2'($urandom_range(0, 3))};
      rdz  = ($urandom_range(0, 3) == 0);
      srcz = ($urandom_range(0, 3) == 0);
      data = srcz ? 32'h0 : $urandom;
      stall_cfg = $urandom_range(0, 2);
      lat_cfg   = $urandom_range(1, 3);
      push_expect(op, addr, data, rdz, srcz);
      issue(op, addr, data, rdz, srcz);
      wait_idle(100);
    end
    rnd_ready = 0;
    stall_cfg = 0; lat_cfg = 1;
    check_drained("back_to_back");
  endtask

  initial begin
    test_reset();
    test_csrrs();
    test_csrrw_rdzero();
    test_readonly();
    test_rd_error();
    test_flush_rd_wait();
    test_rsp_stall();
    test_flush_rsp();
    test_reset_mid();
    test_enable();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/rice_core_csr_access_ctrl.md
RICE_CORE_CSR_ACCESS_CTRL -- requirements
Module: rice_core_csr_access_ctrl

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width of the CSR bus and pipeline operands.
REQ-002 SHALL have ports:
- i_clk  in  1  clock.
- i_rst  in  1  asynchronous active-high reset.
- i_enable  in  1  core enable.
- i_flush  in  1  pipeline flush.
- i_req_valid  in  1  CSR instruction request.
- o_req_ready  out  1  request accept.
- i_req_op  in  2  operation: 01 = RW, 10 = RS, 11 = RC; 00 is reserved.
- i_req_address  in  12  CSR address.
- i_req_data  in  XLEN  rs1 value or zimm.
- i_req_rd_zero  in  1  rd is x0.
- i_req_src_zero  in  1  rs1/zimm is 0.
- o_rsp_valid  out  1  result valid.
- i_rsp_ready  in  1  result accept.
- o_rsp_data  out  XLEN  old CSR value.
- o_rsp_error  out  1  illegal access.
- o_csr_request_valid  out  1  bus request.
- i_csr_request_ready  in  1  bus accept.
- o_csr_address  out  12  bus address.
- o_csr_write  out  1  1 = write, 0 = read.
- o_csr_write_data  out  XLEN  bus write data.
- i_csr_response_valid  in  1  bus response; writes are non-posted.
- i_csr_read_data  in  XLEN  bus read data.
- i_csr_error  in  1  bus error, qualified by i_csr_response_valid.
- o_busy  out  1  FSM not in IDLE.

Function
REQ-003 SHALL implement FSM states IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RSP.
REQ-004 SHALL drive o_req_ready = 1 only in IDLE with i_enable = 1 and i_flush = 0; on accept it SHALL capture op, address, data and the zero flags.
REQ-005 SHALL set need_read = !(op == RW && rd_zero) and need_write = (op == RW) || !src_zero.
REQ-006 On accept, SHALL go to RSP with error = 1 and issue no bus access if op = 00, or if need_write = 1 and address[11:10] = 2'b11 (read-only CSR).
REQ-007 Otherwise, on accept, SHALL go to RD_REQ if need_read = 1, else to WR_REQ.
REQ-008 SHALL hold o_csr_request_valid = 1 in RD_REQ and WR_REQ until i_csr_request_ready = 1, keeping address, write and data stable; it SHALL then go to RD_WAIT or WR_WAIT respectively.
REQ-009 SHALL drive o_csr_write = 1 only in WR_REQ.
REQ-010 In RD_WAIT, on response, SHALL capture i_csr_read_data into o_rsp_data.
- If error: go to RSP with error = 1, no write.
- Else if need_write: go to WR_REQ.
- Else: go to RSP.
REQ-011 SHALL compute write data as follows, latched when entering WR_REQ:
- RW: data.
- RS: read_data | data.
- RC: read_data & ~data.
REQ-012 When read is skipped, o_rsp_data SHALL be 0.
REQ-013 In WR_WAIT, on response, SHALL go to RSP with o_rsp_error = i_csr_error.
REQ-014 SHALL assert o_rsp_valid in RSP, hold o_rsp_data and o_rsp_error stable until i_rsp_ready = 1, then return to IDLE (one-cycle bubble; back-to-back accepts are impossible).
REQ-015 i_flush in RSP SHALL drop the response and return to IDLE the next cycle.
REQ-016 i_flush in RD_*/WR_* SHALL set a discard flag, and the bus transaction SHALL still complete.
REQ-017 A flushed transaction SHALL issue no further write after a read and produce no o_rsp_valid, returning to IDLE after the last bus response.
REQ-018 Flush SHALL never abort an accepted bus request.
REQ-019 i_enable = 0 SHALL block new accepts only; an in-flight operation SHALL complete normally.
REQ-020 Responses arriving in a state other than RD_WAIT/WR_WAIT SHALL be ignored.

Reset
REQ-021 i_rst SHALL asynchronously force IDLE, clear the discard flag, and force outputs to: o_req_ready 0, o_rsp_valid 0, o_rsp_data 0, o_rsp_error 0, o_csr_request_valid 0, o_csr_address 0, o_csr_write 0, o_csr_write_data 0, o_busy 0.
REQ-022 Reset mid-transaction SHALL abandon the operation; the bus side is reset by the same i_rst.

Verification
REQ-023 CSRRS at 0x300, CSR value 0x00000008, data 0x00000080 -> read, then write 0x00000088; o_rsp_data = 0x00000008, error 0.
REQ-024 CSRRW with rd_zero = 1 at 0x340, data 0x12345678 -> no read request, single write 0x12345678; o_rsp_data = 0, error 0.
REQ-025 CSRRC with src_zero = 0 at 0xC00 -> no bus activity, o_rsp_valid with error = 1; CSRRS with src_zero = 1 at 0xC00 -> read only, error 0.
REQ-026 Read response with i_csr_error = 1 at 0x7FF -> no write, o_rsp_error = 1.
REQ-027 i_csr_request_ready held low 5 cycles, then i_flush in RD_WAIT -> request stable throughout, read completes, no write, no o_rsp_valid, o_busy = 0 the cycle after the response.
REQ-028 i_rsp_ready low 3 cycles in RSP -> o_rsp_valid/data held; i_rst pulsed mid WR_WAIT -> all outputs 0 immediately.
